// File: rtl/nvdla_sdp_nrdma_cq_fifo_pkg.sv
// Shared constants for the SDP NRDMA completion-queue FIFO.
//   DEPTH  : number of RAM entries (addresses wrap DEPTH-1 -> 0)
//   WIDTH  : payload width
//   ADR_W  : RAM address width
//   CNT_W  : occupancy counter width (must hold DEPTH)
package nvdla_sdp_nrdma_cq_fifo_pkg;

    localparam int DEPTH = 160;
    localparam int WIDTH = 16;
    localparam int ADR_W = 8;
    localparam int CNT_W = 8;

    // Address increment with wrap at the last entry (not a power of two).
    function automatic logic [ADR_W-1:0] adr_inc(input logic [ADR_W-1:0] adr);
        return (adr == ADR_W'(DEPTH - 1)) ? '0 : adr + 1'b1;
    endfunction

endpackage

// File: rtl/nvdla_sdp_nrdma_cq_fifo_ram.sv
// 160x16 two-port RAM model: synchronous write, registered read address,
// output-enable data register.
//   clk           : RAM clock (gated core clock)
//   pwrbus_ram_pd : power control, no effect in this behavioural model
//   wa/we/di      : write address / enable / data
//   ra/re         : read address / enable (address captured when re=1)
//   dout/ore      : output data register, loaded when ore=1
module nv_ram_rwsp_160x16
    import nvdla_sdp_nrdma_cq_fifo_pkg::*;
(
    input  logic             clk,
    input  logic [31:0]      pwrbus_ram_pd,
    input  logic [ADR_W-1:0] wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
    input  logic [ADR_W-1:0] ra,
    input  logic             re,
    output logic [WIDTH-1:0] dout,
    input  logic             ore
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [ADR_W-1:0] ra_d;
    logic             pwrbus_unused;

    assign pwrbus_unused = ^pwrbus_ram_pd;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= di;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            ra_d <= ra;
        end
    end

    // Same-address read/write contention yields stale data; the FIFO
    // control never reads an entry in the cycle it is written.
    always_ff @(posedge clk) begin
        if (ore) begin
            dout <= mem[ra_d];
        end
    end

endmodule

// File: rtl/nvdla_sdp_nrdma_cq_fifo.sv
// SDP NRDMA completion-queue FIFO, 160 x 16, valid/ready on both sides.
// Ingress descriptors (ig2cq) are buffered for the egress stage (cq2eg).
//   nvdla_core_clk_mgated : gated core clock (control and RAM)
//   nvdla_core_rstn       : async active-low reset
//   ig2cq_pvld/prdy/pd    : ingress handshake and payload
//   cq2eg_pvld/prdy/pd    : egress handshake and payload (RAM output reg)
//   pwrbus_ram_pd         : RAM power control pass-through
//   clk_mgated_enable     : request to the external clock gate
// The write side and read side each keep their own count; they are linked
// by one-cycle delayed push/pop so the RAM write lands before the read side
// ever sees the entry.
module nvdla_sdp_nrdma_cq_fifo
    import nvdla_sdp_nrdma_cq_fifo_pkg::*;
#(
    parameter int WR_LIMIT = 0
) (
    input  logic             nvdla_core_clk_mgated,
    input  logic             nvdla_core_rstn,
    input  logic             ig2cq_pvld,
    output logic             ig2cq_prdy,
    input  logic [WIDTH-1:0] ig2cq_pd,
    output logic             cq2eg_pvld,
    input  logic             cq2eg_prdy,
    output logic [WIDTH-1:0] cq2eg_pd,
    input  logic [31:0]      pwrbus_ram_pd,
    output logic             clk_mgated_enable
);

    logic             busy;
    logic             busy_next;
    logic [CNT_W-1:0] wr_count;
    logic [CNT_W-1:0] wr_count_next;
    logic [ADR_W-1:0] wr_adr;
    logic             push;
    logic             wr_popping;

    logic             rd_pushing;
    logic             rd_popping;
    logic [CNT_W-1:0] rd_count_p;
    logic [CNT_W-1:0] rd_count_p_next;
    logic             pvld_p;
    logic [ADR_W-1:0] rd_adr;
    logic [ADR_W-1:0] rd_ra;
    logic             rd_re;

    // ---------------- write side ----------------
    assign ig2cq_prdy    = !busy;
    assign push          = ig2cq_pvld && !busy;
    assign wr_count_next = wr_count + CNT_W'(push) - CNT_W'(wr_popping);

    // Freed space is only visible once the delayed pop arrives, so a full
    // FIFO stays busy unless a pop is landing this cycle.
    always_comb begin
        busy_next = (!wr_popping &&
                     (({1'b0, wr_count} + (CNT_W + 1)'(push)) == (CNT_W + 1)'(DEPTH)));
        if (WR_LIMIT != 0 && int'(wr_count_next) >= WR_LIMIT) begin
            busy_next = 1'b1;
        end
    end

    always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            busy       <= 1'b0;
            wr_count   <= '0;
            wr_adr     <= '0;
            wr_popping <= 1'b0;
            rd_pushing <= 1'b0;
        end else begin
            busy       <= busy_next;
            wr_count   <= wr_count_next;
            wr_popping <= rd_popping;
            rd_pushing <= push;
            if (push) begin
                wr_adr <= adr_inc(wr_adr);
            end
        end
    end

    // ---------------- read side ----------------
    // An entry leaves the RAM into the output register whenever the output
    // register is empty or being drained this cycle.
    assign rd_popping      = pvld_p && !(cq2eg_pvld && !cq2eg_prdy);
    assign rd_count_p_next = rd_count_p + CNT_W'(rd_pushing) - CNT_W'(rd_popping);
    assign rd_ra           = rd_popping ? adr_inc(rd_adr) : rd_adr;
    assign rd_re           = (rd_count_p_next != '0) && (!pvld_p || rd_popping);

    always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rd_count_p <= '0;
            pvld_p     <= 1'b0;
            rd_adr     <= '0;
            cq2eg_pvld <= 1'b0;
        end else begin
            if (rd_pushing || rd_popping) begin
                rd_count_p <= rd_count_p_next;
                pvld_p     <= (rd_count_p_next != '0);
            end
            if (rd_popping) begin
                rd_adr <= adr_inc(rd_adr);
            end
            cq2eg_pvld <= pvld_p || (cq2eg_pvld && !cq2eg_prdy);
        end
    end

    nv_ram_rwsp_160x16 u_ram (
        .clk           (nvdla_core_clk_mgated),
        .pwrbus_ram_pd (pwrbus_ram_pd),
        .wa            (wr_adr),
        .we            (push),
        .di            (ig2cq_pd),
        .ra            (rd_ra),
        .re            (rd_re),
        .dout          (cq2eg_pd),
        .ore           (rd_popping)
    );

    assign clk_mgated_enable = push || rd_popping || wr_popping || rd_pushing ||
                               (busy != busy_next) || (cq2eg_pvld && cq2eg_prdy);

endmodule

// File: tb/tb_nvdla_sdp_nrdma_cq_fifo.sv
module tb_nvdla_sdp_nrdma_cq_fifo;

    logic        clk;
    logic        rstn;
    logic        ig2cq_pvld;
    logic        ig2cq_prdy;
    logic [15:0] ig2cq_pd;
    logic        cq2eg_pvld;
    logic        cq2eg_prdy;
    logic [15:0] cq2eg_pd;
    logic [31:0] pwrbus_ram_pd;
    logic        clk_mgated_enable;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered queue of accepted words.
    logic [15:0] sb[$];
    int          cyc = 0;
    int          n_out = 0;
    int          first_out = 0;
    int          last_out = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_pd = 0;

    nvdla_sdp_nrdma_cq_fifo dut (
        .nvdla_core_clk_mgated (clk),
        .nvdla_core_rstn       (rstn),
        .ig2cq_pvld            (ig2cq_pvld),
        .ig2cq_prdy            (ig2cq_prdy),
        .ig2cq_pd              (ig2cq_pd),
        .cq2eg_pvld            (cq2eg_pvld),
        .cq2eg_prdy            (cq2eg_prdy),
        .cq2eg_pd              (cq2eg_pd),
        .pwrbus_ram_pd         (pwrbus_ram_pd),
        .clk_mgated_enable     (clk_mgated_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called just after a falling edge with inputs already set: score the
    // handshakes that the coming rising edge will complete, then advance.
    task automatic step();
        logic [15:0] exp;
        if (prev_stall) begin
            chk("stall_pvld", 32'(cq2eg_pvld), 32'd1);
            chk("stall_pd", 32'(cq2eg_pd), 32'(prev_pd));
        end
        if (ig2cq_pvld && ig2cq_prdy) sb.push_back(ig2cq_pd);
        if (cq2eg_pvld && cq2eg_prdy) begin
            if (sb.size() == 0) begin
                chk("pop_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                exp = sb.pop_front();
                chk("data", 32'(cq2eg_pd), 32'(exp));
            end
            if (n_out == 0) first_out = cyc;
            last_out = cyc;
            n_out++;
        end
        prev_stall = cq2eg_pvld && !cq2eg_prdy;
        prev_pd    = cq2eg_pd;
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        ig2cq_pvld = 1'b0;
        cq2eg_prdy = 1'b1;
        for (int i = 0; i < 600 && (sb.size() != 0 || cq2eg_pvld); i++) step();
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_pvld", 32'(cq2eg_pvld), 32'd0);
    endtask

    task automatic fill(input int n);
        cq2eg_prdy = 1'b0;
        for (int i = 0; i < n; i++) begin
            ig2cq_pvld = 1'b1;
            ig2cq_pd   = 16'(16'h1000 + i);
            step();
        end
        ig2cq_pvld = 1'b0;
    endtask

    initial begin
        int acc;
        int start;
        int sent;
        rstn          = 1'b0;
        ig2cq_pvld    = 1'b0;
        ig2cq_pd      = '0;
        cq2eg_prdy    = 1'b0;
        pwrbus_ram_pd = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        chk("rst_prdy", 32'(ig2cq_prdy), 32'd1);
        chk("rst_pvld", 32'(cq2eg_pvld), 32'd0);
        chk("rst_wr_count", 32'(dut.wr_count), 32'd0);
        chk("rst_rd_count", 32'(dut.rd_count_p), 32'd0);
        chk("rst_enable", 32'(clk_mgated_enable), 32'd0);

        // Single word latency: accepted at cycle 0, visible at cycle 3 only.
        ig2cq_pvld = 1'b1; ig2cq_pd = 16'hA5A5; cq2eg_prdy = 1'b1;
        step();
        ig2cq_pvld = 1'b0;
        step();
        chk("lat_pvld_c2", 32'(cq2eg_pvld), 32'd0);
        step();
        chk("lat_pvld_c3", 32'(cq2eg_pvld), 32'd1);
        chk("lat_pd_c3", 32'(cq2eg_pd), 32'hA5A5);
        step();
        chk("lat_pvld_c4", 32'(cq2eg_pvld), 32'd0);
        drain();

        // Fill with the egress stalled: RAM holds 160 plus the output register.
        cq2eg_prdy = 1'b0;
        acc = 0;
        for (int i = 0; i < 300 && ig2cq_prdy; i++) begin
            ig2cq_pvld = 1'b1;
            ig2cq_pd   = 16'(acc);
            step();
            acc++;
        end
        chk("full_accepts", 32'(acc), 32'd161);
        chk("full_prdy", 32'(ig2cq_prdy), 32'd0);
        ig2cq_pvld = 1'b0;
        step();
        chk("full_prdy_hold", 32'(ig2cq_prdy), 32'd0);
        cq2eg_prdy = 1'b1;
        step();
        cq2eg_prdy = 1'b0;
        chk("pop_prdy_p1", 32'(ig2cq_prdy), 32'd0);
        step();
        chk("pop_prdy_p2", 32'(ig2cq_prdy), 32'd1);
        drain();

        // Back-to-back stream of 500 words, no bubbles after initial latency.
        n_out = 0;
        start = cyc;
        cq2eg_prdy = 1'b1;
        for (int i = 0; i < 500; i++) begin
            ig2cq_pvld = 1'b1;
            ig2cq_pd   = 16'(i);
            step();
        end
        drain();
        chk("stream_count", 32'(n_out), 32'd500);
        chk("stream_first_lat", 32'(first_out - start), 32'd3);
        chk("stream_no_bubble", 32'(last_out - first_out + 1), 32'd500);

        // Random stalls on both sides, 1000 words.
        sent = 0;
        for (int i = 0; i < 20000 && sent < 1000; i++) begin
            ig2cq_pvld = ($urandom % 4) != 0;
            ig2cq_pd   = 16'($urandom);
            cq2eg_prdy = ($urandom % 3) != 0;
            if (ig2cq_pvld && ig2cq_prdy) sent++;
            step();
        end
        chk("rand_sent", 32'(sent), 32'd1000);
        drain();

        // Steady occupancy 80 with simultaneous push and pop.
        fill(81);
        cq2eg_prdy = 1'b0;
        repeat (3) step();
        cq2eg_prdy = 1'b1;
        step();
        for (int i = 0; i < 40; i++) begin
            ig2cq_pvld = 1'b1;
            ig2cq_pd   = 16'(16'h2000 + i);
            chk("occ_wr_count", 32'(dut.wr_count), 32'd80);
            chk("occ_prdy", 32'(ig2cq_prdy), 32'd1);
            step();
        end
        drain();

        // Reset with 50 entries stored.
        fill(50);
        repeat (2) step();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        sb.delete();
        prev_stall = 0;
        chk("mrst_prdy", 32'(ig2cq_prdy), 32'd1);
        chk("mrst_pvld", 32'(cq2eg_pvld), 32'd0);
        chk("mrst_wr_count", 32'(dut.wr_count), 32'd0);
        chk("mrst_rd_count", 32'(dut.rd_count_p), 32'd0);
        ig2cq_pvld = 1'b1; ig2cq_pd = 16'h5A3C; cq2eg_prdy = 1'b1;
        step();
        ig2cq_pvld = 1'b0;
        step();
        step();
        chk("mrst_lat_pvld", 32'(cq2eg_pvld), 32'd1);
        chk("mrst_lat_pd", 32'(cq2eg_pd), 32'h5A3C);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
